// File: rtl/mul_limb_seq_if.sv
// Handshake bundle for mul_limb_seq: operand request channel, product response channel and busy flag.
// The slave modport is the multiplier; the master modport is whoever feeds operands and takes products.
interface mul_limb_seq_if #(
  parameter int LIMB_W = 16,
  parameter int NLIMB  = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [NLIMB*LIMB_W-1:0]    a;
  logic [NLIMB*LIMB_W-1:0]    b;
  logic                       out_valid;
  logic                       out_ready;
  logic [2*NLIMB*LIMB_W-1:0]  y;
  logic                       busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/mul_limb_seq.sv
// Sequential schoolbook multiplier: one LIMB_W x LIMB_W partial product per clock,
// accumulated into a full-width product register that drives y directly.
module mul_limb_seq #(
  parameter int LIMB_W = 16,
  parameter int NLIMB  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_limb_seq_if.slave bus
);
  localparam int OP_W  = NLIMB * LIMB_W;
  localparam int ACC_W = 2 * OP_W;
  localparam int PP_W  = 2 * LIMB_W;
  localparam int IDX_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMB - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [OP_W-1:0]  a_q, a_d;
  logic [OP_W-1:0]  b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic [31:0]       a_sh, b_sh, pp_sh;
  logic [LIMB_W-1:0] a_limb, b_limb;
  logic [PP_W-1:0]   pp;
  logic [ACC_W-1:0]  pp_shifted;

  // Limb selection by shifting keeps NLIMB=1 legal without zero-width index logic.
  always_comb begin
    a_sh       = 32'(i_q) * 32'(LIMB_W);
    b_sh       = 32'(j_q) * 32'(LIMB_W);
    pp_sh      = (32'(i_q) + 32'(j_q)) * 32'(LIMB_W);
    a_limb     = LIMB_W'(a_q >> a_sh);
    b_limb     = LIMB_W'(b_q >> b_sh);
    pp         = PP_W'(a_limb) * PP_W'(b_limb);
    pp_shifted = ACC_W'(pp) << pp_sh;
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        acc_d = acc_q + pp_shifted;
        if (j_q == LAST_IDX) begin
          j_d = '0;
          if (i_q == LAST_IDX) begin
            i_d     = '0;
            state_d = ST_DONE;
          end else begin
            i_d = i_q + IDX_W'(1);
          end
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.y         = acc_q;
endmodule

// File: tb/tb_mul_limb_seq.sv
// Directed and randomized checks of mul_limb_seq at 16x2, 8x4 and 16x1 limb geometries
// against a plain wide-integer product.
module tb_mul_limb_seq;
  logic clk = 1'b0;
  logic rst0_n;
  logic rsts_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_limb_seq_if #(.LIMB_W(16), .NLIMB(2)) if0 ();
  mul_limb_seq_if #(.LIMB_W(8),  .NLIMB(4)) if1 ();
  mul_limb_seq_if #(.LIMB_W(16), .NLIMB(1)) if2 ();

  mul_limb_seq #(.LIMB_W(16), .NLIMB(2)) u_16x2 (.clk(clk), .rst_n(rst0_n), .bus(if0));
  mul_limb_seq #(.LIMB_W(8),  .NLIMB(4)) u_8x4  (.clk(clk), .rst_n(rsts_n), .bus(if1));
  mul_limb_seq #(.LIMB_W(16), .NLIMB(1)) u_16x1 (.clk(clk), .rst_n(rsts_n), .bus(if2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa, wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  task automatic set_in(input int s, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic ordy);
    case (s)
      0: begin if0.in_valid = v; if0.a = a; if0.b = b; if0.out_ready = ordy; end
      1: begin if1.in_valid = v; if1.a = a; if1.b = b; if1.out_ready = ordy; end
      default: begin if2.in_valid = v; if2.a = a[15:0]; if2.b = b[15:0]; if2.out_ready = ordy; end
    endcase
  endtask

  function automatic logic get_in_ready(input int s);
    case (s)
      0: return if0.in_ready;
      1: return if1.in_ready;
      default: return if2.in_ready;
    endcase
  endfunction

  function automatic logic get_out_valid(input int s);
    case (s)
      0: return if0.out_valid;
      1: return if1.out_valid;
      default: return if2.out_valid;
    endcase
  endfunction

  function automatic logic get_busy(input int s);
    case (s)
      0: return if0.busy;
      1: return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic [63:0] get_y(input int s);
    case (s)
      0: return if0.y;
      1: return if1.y;
      default: return {32'd0, if2.y};
    endcase
  endfunction

  // One full transaction with out_ready held high; checks acceptance, latency and product.
  task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input string tag);
    int          n;
    logic        acc;
    logic [63:0] exp_y;
    logic [63:0] got_y;
    exp_y = ref_mul(a, b);
    set_in(s, 1'b1, a, b, 1'b1);
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      acc = get_in_ready(s);
      tick();
      n++;
    end
    chk({tag, "_accept"}, 64'(acc), 64'd1);
    set_in(s, 1'b0, a, b, 1'b1);
    n = 0;
    while (!get_out_valid(s) && n < 100) begin
      tick();
      n++;
    end
    got_y = get_y(s);
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_y"}, got_y, exp_y);
    $display("op %s inst=%0d a=%h b=%h y=%h lat=%0d", tag, s, a, b, got_y, n);
    tick();
  endtask

  function automatic logic [31:0] rand_operand(input logic [31:0] mask);
    case ($urandom_range(0, 5))
      0: return mask;
      1: return 32'd0;
      default: return $urandom & mask;
    endcase
  endfunction

  logic [31:0] sa [5];
  logic [31:0] sb [5];
  int          acc_cyc [5];
  logic [63:0] exp_q [$];

  initial begin
    rst0_n = 1'b0;
    rsts_n = 1'b0;
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 32'd0, 32'd0, 1'b1);
    tick();
    tick();
    rst0_n = 1'b1;
    rsts_n = 1'b1;
    tick();

    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset_in_ready%0d", s), 64'(get_in_ready(s)), 64'd1);
      chk($sformatf("reset_out_valid%0d", s), 64'(get_out_valid(s)), 64'd0);
      chk($sformatf("reset_busy%0d", s), 64'(get_busy(s)), 64'd0);
      chk($sformatf("reset_y%0d", s), get_y(s), 64'd0);
    end

    run_op(0, 32'h0001_0002, 32'h0003_0004, 4, "basic");
    chk("basic_const", if0.y, 64'h0000_0003_000A_0008);
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, "max");
    chk("max_const", if0.y, 64'hFFFF_FFFE_0000_0001);
    run_op(0, 32'h0000_0000, 32'hFFFF_FFFF, 4, "zero");

    // Backpressure: result must hold while new operands are offered.
    set_in(0, 1'b1, 32'd7, 32'd9, 1'b0);
    tick();
    set_in(0, 1'b1, 32'h55, 32'h66, 1'b0);
    for (int n = 0; n < 20 && !if0.out_valid; n++) tick();
    for (int c = 0; c < 10; c++) begin
      chk("bp_y", if0.y, 64'd63);
      chk("bp_out_valid", 64'(if0.out_valid), 64'd1);
      chk("bp_in_ready", 64'(if0.in_ready), 64'd0);
      chk("bp_busy", 64'(if0.busy), 64'd1);
      tick();
    end
    $display("op backpressure inst=0 a=7 b=9 y=%h", if0.y);
    set_in(0, 1'b0, 32'h55, 32'h66, 1'b1);
    tick();
    chk("bp_release_out_valid", 64'(if0.out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(if0.in_ready), 64'd1);
    chk("bp_release_y_hold", if0.y, 64'd63);

    // Asynchronous reset during the second MUL cycle.
    set_in(0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    tick();
    set_in(0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    tick();
    #2;
    rst0_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(if0.out_valid), 64'd0);
    chk("rst_y", if0.y, 64'd0);
    chk("rst_busy", 64'(if0.busy), 64'd0);
    chk("rst_in_ready", 64'(if0.in_ready), 64'd1);
    $display("op reset_abort inst=0 a=12345678 b=9abcdef0 y=%h", if0.y);
    tick();
    rst0_n = 1'b1;
    tick();
    run_op(0, 32'd3, 32'd5, 4, "after_rst");

    // Streaming: in_valid and out_ready stay high; accepts must be 6 cycles apart.
    for (int k = 0; k < 5; k++) begin
      sa[k] = $urandom;
      sb[k] = $urandom;
    end
    begin
      int   cyc;
      int   k;
      int   r;
      logic acc_now;
      logic out_now;
      logic [63:0] yv;
      logic [63:0] ev;
      cyc = 0;
      k   = 0;
      r   = 0;
      set_in(0, 1'b1, sa[0], sb[0], 1'b1);
      while (r < 5 && cyc < 200) begin
        acc_now = if0.in_ready && if0.in_valid;
        out_now = if0.out_valid;
        yv      = if0.y;
        tick();
        cyc++;
        if (acc_now) begin
          acc_cyc[k] = cyc;
          exp_q.push_back(ref_mul(sa[k], sb[k]));
          k++;
          if (k < 5) set_in(0, 1'b1, sa[k], sb[k], 1'b1);
          else       set_in(0, 1'b0, 32'd0, 32'd0, 1'b1);
        end
        if (out_now) begin
          ev = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
          chk($sformatf("stream_y%0d", r), yv, ev);
          $display("op stream%0d inst=0 y=%h", r, yv);
          r++;
        end
      end
      chk("stream_results", 64'(r), 64'd5);
      for (int q = 1; q < 5 && q < k; q++)
        chk($sformatf("stream_spacing%0d", q), 64'(acc_cyc[q] - acc_cyc[q-1]), 64'd6);
    end

    // Parameter sweep against the reference product.
    for (int t = 0; t < 1000; t++)
      run_op(1, rand_operand(32'hFFFF_FFFF), rand_operand(32'hFFFF_FFFF), 16, "sweep8x4");
    for (int t = 0; t < 1000; t++)
      run_op(2, rand_operand(32'h0000_FFFF), rand_operand(32'h0000_FFFF), 1, "sweep16x1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_limb_seq.md
Name: mul_limb_seq

Overview:
- Parametrised, sequential successor to the fixed 2x2-limb combinational multiplier cells.
- Computes the full unsigned product of two NLIMB-limb operands by schoolbook multiply-accumulate.
- Uses one LIMB_W x LIMB_W partial product per clock, with valid/ready handshakes on input and output.
- Serves as the golden sequential datapath for the mul4-style vector tournament benches. Limb width and limb count are generalised beyond 16-bit x 2.

Parameters:
- LIMB_W, 16, width of one limb in bits (>=2).
- NLIMB, 2, limbs per operand (>=1); operand width is NLIMB*LIMB_W, product width is 2*NLIMB*LIMB_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a,b valid.
- in_ready  out  1  block can accept operands.
- a  in  NLIMB*LIMB_W  multiplicand; limb k = a[k*LIMB_W +: LIMB_W], limb 0 least significant.
- b  in  NLIMB*LIMB_W  multiplier, same limb packing.
- out_valid  out  1  y holds a completed product.
- out_ready  in  1  consumer accepts y.
- y  out  2*NLIMB*LIMB_W  unsigned product a*b; word k = y[k*LIMB_W +: LIMB_W] (y0 = lowest word).
- busy  out  1  high in MUL or DONE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Reset values: state=IDLE, y=0, out_valid=0, busy=0, in_ready=1, limb indices i=j=0, latched operands=0.
  - Reset asserted mid-MUL or mid-DONE aborts immediately; the partial result is discarded and is never presented.
- FSM with states IDLE, MUL, DONE:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge: latch a and b, clear the accumulator, set i=j=0, go to MUL.
  - MUL: each edge adds zero-extended (a_i*b_j) << ((i+j)*LIMB_W) into the accumulator, then advances j; when j wraps from NLIMB-1 to 0, i advances.
    - The edge that processes i=j=NLIMB-1 moves to DONE.
    - Exactly NLIMB*NLIMB MUL edges per operation.
  - DONE: out_valid=1 and y is stable. On out_valid&&out_ready at an edge: go to IDLE and drop out_valid; y keeps its last value.
- in_ready is 1 only in IDLE; there is no overlap of successive operations. in_valid outside IDLE is ignored, and the operands are not latched.
- Latency: out_valid rises NLIMB*NLIMB cycles after the accepting edge.
  - With out_ready held high, throughput is one result per NLIMB*NLIMB+2 cycles.
- y is driven directly from the accumulator register; no combinational path from a or b to y.
- Width rules:
  - The accumulator is 2*NLIMB*LIMB_W bits. The final sum never overflows, since the max product (2^W-1)^2 < 2^(2W).
  - Each partial product is 2*LIMB_W bits, zero-extended before the shift.
  - All arithmetic is unsigned.
- Operand changes after the accepting edge have no effect on the running operation.
- out_ready may be held low indefinitely; DONE holds with y, out_valid and busy stable.
- NLIMB=1 degenerates to one MUL cycle; it must still produce the correct result.

Test Plan:
- LIMB_W=16, NLIMB=2, a=0x00010002, b=0x00030004, out_ready=1.
  - Response: out_valid rises exactly 4 cycles after acceptance; y=0x00000003000A0008 (y3=0x0000, y2=0x0003, y1=0x000A, y0=0x0008).
- Max operands a=b=0xFFFFFFFF.
  - Response: y=0xFFFFFFFE00000001 with no carry loss; then a=0, b=0xFFFFFFFF gives y=0.
- Backpressure: complete a=7, b=9, hold out_ready=0 for 10 cycles while in_valid=1 with new operands.
  - Response: y=63 stable, out_valid=1, in_ready=0, new operands not latched.
  - On out_ready=1: one handshake, then IDLE and in_ready=1.
- Reset mid-MUL: deassert rst_n asynchronously (between edges) during the 2nd MUL cycle of a=0x12345678, b=0x9ABCDEF0.
  - Response: out_valid, y and busy drop to 0 immediately; in_ready=1.
  - The next transaction a=3, b=5 yields y=15 with correct latency.
- Streaming with out_ready=1 and in_valid=1 continuously for 5 transactions.
  - Response: accepts spaced exactly 6 cycles apart; each y matches its own operands.
- Parameter sweep LIMB_W=8,NLIMB=4 and LIMB_W=16,NLIMB=1 with 1000 random operand pairs each.
  - Response: y equals the wide-integer reference product.
  - out_valid latency equals 16 and 1 cycles respectively.
